// File: rtl/div_iter.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU in EX.
// Returns {remainder, quotient} after WIDTH iterations plus a sign fix-up cycle.
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               StartDivE,
  input  logic               SignedDivE,
  input  logic [WIDTH-1:0]   SrcAE,
  input  logic [WIDTH-1:0]   SrcBE,
  input  logic               DivAnnul,
  input  logic               DivHold,
  output logic               DivReadyE,
  output logic [2*WIDTH-1:0] DivResultE
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state, state_next;
  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   rem, quo, dvsr;
  logic               neg_q, neg_r;
  logic [2*WIDTH-1:0] result;

  logic               sign_a, sign_b;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH+1:0]   trial;
  logic               trial_ok;
  logic [WIDTH-1:0]   rem_step, quo_step, quo_fix, rem_fix;
  logic               last_step;

  assign sign_a = SignedDivE & SrcAE[WIDTH-1];
  assign sign_b = SignedDivE & SrcBE[WIDTH-1];
  assign abs_a  = sign_a ? (~SrcAE + 1'b1) : SrcAE;
  assign abs_b  = sign_b ? (~SrcBE + 1'b1) : SrcBE;

  // Shift the next dividend bit into the partial remainder and try a subtract.
  // Divisor zero always "succeeds", leaving quotient all-ones and rem = dividend.
  assign rem_sh   = {rem, quo[WIDTH-1]};
  assign trial    = {1'b0, rem_sh} - {2'b00, dvsr};
  assign trial_ok = ~trial[WIDTH+1];
  assign rem_step = trial_ok ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign quo_step = {quo[WIDTH-2:0], trial_ok};

  assign quo_fix   = neg_q ? (~quo + 1'b1) : quo;
  assign rem_fix   = neg_r ? (~rem + 1'b1) : rem;
  assign last_step = (count == CW'(WIDTH));

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (StartDivE) state_next = BUSY;
      BUSY:    if (last_step) state_next = DONE;
      DONE:    if (!DivHold)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (DivAnnul) state_next = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      count  <= '0;
      rem    <= '0;
      quo    <= '0;
      dvsr   <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      result <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (state_next == BUSY) begin
            rem   <= '0;
            quo   <= abs_a;
            dvsr  <= abs_b;
            count <= '0;
            neg_q <= sign_a ^ sign_b;
            neg_r <= sign_a;
          end
        end
        BUSY: begin
          if (!last_step) begin
            rem   <= rem_step;
            quo   <= quo_step;
            count <= count + 1'b1;
          end else if (state_next == DONE) begin
            result <= {rem_fix, quo_fix};
          end
        end
        default: ;
      endcase
    end
  end

  assign DivReadyE  = (state == DONE);
  assign DivResultE = result;

endmodule

// File: tb/tb_div_iter.sv
// Directed bench for div_iter: expected results queued at issue, popped at ready.
module tb_div_iter;
  logic        clk = 1'b0;
  logic        rst;
  logic        StartDivE, SignedDivE, DivAnnul, DivHold;
  logic [31:0] SrcAE, SrcBE;
  logic        DivReadyE;
  logic [63:0] DivResultE;

  div_iter #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .StartDivE(StartDivE), .SignedDivE(SignedDivE),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .DivAnnul(DivAnnul), .DivHold(DivHold),
    .DivReadyE(DivReadyE), .DivResultE(DivResultE)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [63:0] sb[$];
  int passed = 0, total = 0, fails = 0;
  int rise_cyc, fall_cyc;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(bit sg, logic [31:0] a, logic [31:0] b);
    int sa, sbv, q, r;
    if (sg) begin
      sa = a; sbv = b;
      q = sa / sbv; r = sa % sbv;
      return {r[31:0], q[31:0]};
    end
    return {a % b, a / b};
  endfunction

  // Issue one divide at an IDLE cycle, keep StartDivE high until it retires.
  task automatic run_op(string tag, bit sg, logic [31:0] a, logic [31:0] b,
                        logic [63:0] exp, int hold);
    logic [63:0] want;
    int k;
    sb.push_back(exp);
    SignedDivE = sg; SrcAE = a; SrcBE = b; StartDivE = 1'b1;
    tick();
    SrcAE = $urandom; SrcBE = $urandom;
    k = 0;
    do begin tick(); k++; end while (!DivReadyE && k < 40);
    rise_cyc = cyc;
    check({tag, " latency"}, 64'(k), 64'd33);
    want = sb.pop_front();
    check({tag, " result"}, DivResultE, want);
    $display("op %s sg=%0d a=%h b=%h -> %h (latency %0d)", tag, sg, a, b, DivResultE, k);
    for (int i = 0; i < hold; i++) begin
      DivHold = 1'b1;
      tick();
      check({tag, " hold ready"}, 64'(DivReadyE), 64'd1);
      check({tag, " hold result"}, DivResultE, want);
    end
    DivHold = 1'b0;
    tick();
    fall_cyc = cyc;
    StartDivE = 1'b0;
    check({tag, " ready drop"}, 64'(DivReadyE), 64'd0);
    check({tag, " result kept"}, DivResultE, want);
  endtask

  task automatic quiet(string tag, int n);
    int seen = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (DivReadyE) seen++;
    end
    check({tag, " no ready"}, 64'(seen), 64'd0);
  endtask

  initial begin
    logic [31:0] a, b;
    bit sg;
    int rise1, fall1;
    rst = 1'b1; StartDivE = 1'b0; SignedDivE = 1'b0; DivAnnul = 1'b0; DivHold = 1'b0;
    SrcAE = '0; SrcBE = '0;
    tick(); tick();
    check("reset ready", 64'(DivReadyE), 64'd0);
    check("reset result", DivResultE, 64'd0);
    rst = 1'b0;
    tick();

    run_op("divu_100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 0);

    // Asynchronous reset mid-BUSY clears everything immediately.
    SignedDivE = 1'b0; SrcAE = 32'd50; SrcBE = 32'd3; StartDivE = 1'b1;
    tick(); StartDivE = 1'b0;
    repeat (5) tick();
    #2 rst = 1'b1;
    #1;
    check("async rst ready", 64'(DivReadyE), 64'd0);
    check("async rst result", DivResultE, 64'd0);
    @(negedge clk) rst = 1'b0;
    tick();

    run_op("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 0);
    run_op("div_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 0);
    run_op("div_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 0);
    run_op("divu_5_0", 1'b0, 32'd5, 32'd0, 64'h00000005_FFFFFFFF, 0);
    run_op("div_m7_0", 1'b1, 32'hFFFFFFF9, 32'd0, 64'hFFFFFFF9_00000001, 0);

    // Start with annul in IDLE is dropped.
    SignedDivE = 1'b0; SrcAE = 32'd8; SrcBE = 32'd2; StartDivE = 1'b1; DivAnnul = 1'b1;
    tick();
    StartDivE = 1'b0; DivAnnul = 1'b0;
    quiet("start_annul", 40);

    // Annul in the 10th BUSY cycle, then a fresh op right away.
    SignedDivE = 1'b0; SrcAE = 32'd1000; SrcBE = 32'd7; StartDivE = 1'b1;
    tick(); StartDivE = 1'b0;
    repeat (9) tick();
    DivAnnul = 1'b1;
    tick();
    DivAnnul = 1'b0;
    check("annul ready", 64'(DivReadyE), 64'd0);
    run_op("divu_9_3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 0);

    run_op("hold3", 1'b0, 32'd77, 32'd5, {32'd2, 32'd15}, 3);
    quiet("after_hold", 40);

    run_op("b2b_1", 1'b0, 32'd10, 32'd3, {32'd1, 32'd3}, 0);
    rise1 = rise_cyc; fall1 = fall_cyc;
    run_op("b2b_2", 1'b0, 32'd20, 32'd6, {32'd2, 32'd3}, 0);
    check("b2b rise spacing", 64'(rise_cyc - rise1), 64'd35);
    check("b2b low gap", 64'(rise_cyc - fall1), 64'd34);

    for (int i = 0; i < 6; i++) begin
      sg = i[0];
      a = $urandom;
      b = $urandom_range(1, 1000);
      if (sg && (i % 3 == 1)) b = ~b + 1'b1;
      if (i == 4) b = $urandom | 32'h1;
      if (sg && b == 32'hFFFFFFFF) b = 32'd3;
      run_op($sformatf("rand%0d", i), sg, a, b, model(sg, a, b), 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
